// File: rtl/ext_mem_pkg.sv
// Shared definitions for the external memory slave: default geometry,
// latency defaults, access classification and small helper functions.
package ext_mem_pkg;

    localparam int DEF_CHANNELS    = 2;
    localparam int DEF_ADDR_W      = 7;
    localparam int DEF_DATA_W      = 8;
    localparam int DEF_SIZE_W      = 4;
    localparam int DEF_MEMSIZE     = 32;
    localparam int DEF_BASE_ADDR   = 0;
    localparam int DEF_READ_DELAY  = 2;
    localparam int DEF_WRITE_DELAY = 1;

    // What a channel is asking for in the current cycle.
    typedef enum logic [1:0] {
        OP_IDLE,
        OP_READ,
        OP_WRITE,
        OP_CONFLICT
    } access_e;

    // Byte-lane style mask from an access size given in bits; sizes at or
    // beyond the data width select the whole word.
    function automatic logic [63:0] size_to_mask(input logic [31:0] size,
                                                 input int unsigned width);
        int unsigned eff;
        eff = (size < width) ? size : width;
        if (eff >= 64) begin
            return {64{1'b1}};
        end
        return (64'd1 << eff) - 64'd1;
    endfunction

    // True when a bus address falls inside the mapped storage window.
    function automatic logic in_range(input logic [31:0] addr,
                                      input int unsigned base,
                                      input int unsigned memsize);
        return (addr >= base) && (addr < base + memsize);
    endfunction

endpackage

// File: rtl/ext_mem_slave_if.sv
// Two-channel master bus between the accelerator and the memory slave.
interface ext_mem_slave_if
    import ext_mem_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int SIZE_W   = DEF_SIZE_W
);
    logic [CHANNELS-1:0]        Mout_oe_ram;
    logic [CHANNELS-1:0]        Mout_we_ram;
    logic [CHANNELS*ADDR_W-1:0] Mout_addr_ram;
    logic [CHANNELS*DATA_W-1:0] Mout_Wdata_ram;
    logic [CHANNELS*SIZE_W-1:0] Mout_data_ram_size;
    logic [CHANNELS*DATA_W-1:0] M_Rdata_ram;
    logic [CHANNELS-1:0]        M_DataRdy;

    modport master (
        output Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram, Mout_data_ram_size,
        input  M_Rdata_ram, M_DataRdy
    );

    modport slave (
        input  Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram, Mout_data_ram_size,
        output M_Rdata_ram, M_DataRdy
    );
endinterface

// File: rtl/ext_mem_channel.sv
// One memory channel: address decode, latency counter, read-data pipeline,
// completion strobe and sticky oe/we conflict detection. Storage lives in
// the top level; this block only tells it where and how to write.
module ext_mem_channel
    import ext_mem_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int SIZE_W      = DEF_SIZE_W,
    parameter int MEMSIZE     = DEF_MEMSIZE,
    parameter int BASE_ADDR   = DEF_BASE_ADDR,
    parameter int READ_DELAY  = DEF_READ_DELAY,
    parameter int WRITE_DELAY = DEF_WRITE_DELAY
)
(
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       oe,
    input  logic                       we,
    input  logic [ADDR_W-1:0]          addr,
    input  logic [SIZE_W-1:0]          size,
    input  logic [DATA_W-1:0]          fetch,
    output logic [$clog2(MEMSIZE)-1:0] off,
    output logic                       wr_en,
    output logic [DATA_W-1:0]          wr_mask,
    output logic [DATA_W-1:0]          rdata,
    output logic                       data_rdy,
    output logic                       err
);
    localparam int IDX_W  = $clog2(MEMSIZE);
    localparam int CNT_W  = $clog2((READ_DELAY > WRITE_DELAY) ? READ_DELAY : WRITE_DELAY);
    localparam int STAGES = READ_DELAY - 1;

    access_e           kind;
    logic              hit;
    logic              rd_last;
    logic              wr_last;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] pipe [STAGES];

    assign hit     = in_range(32'(addr), BASE_ADDR, MEMSIZE);
    assign off     = IDX_W'(addr - ADDR_W'(BASE_ADDR));
    assign wr_mask = DATA_W'(size_to_mask(32'(size), DATA_W));
    assign wr_en   = hit && (kind == OP_WRITE);
    assign rd_last = (32'(cnt) == 32'(READ_DELAY - 1));
    assign wr_last = (32'(cnt) == 32'(WRITE_DELAY - 1));

    // Raw data sits in `we` for the write check so a conflicting access
    // still reports completion through the write term, as the master sees it.
    assign data_rdy = hit && (rd_last || (we && wr_last));
    assign rdata    = pipe[STAGES-1];

    // Classify the request; a conflicting oe+we is counted like a read.
    always_comb begin
        kind = OP_IDLE;
        if (oe && we) begin
            kind = OP_CONFLICT;
        end else if (oe) begin
            kind = OP_READ;
        end else if (we) begin
            kind = OP_WRITE;
        end
    end

    // Latency counter: walks through the read or write delay while an
    // in-range access is held and wraps so a held access repeats.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt <= '0;
        end else if (hit && (kind == OP_READ || kind == OP_CONFLICT)) begin
            cnt <= (32'(cnt) + 32'd1 < 32'(READ_DELAY)) ? cnt + CNT_W'(1) : '0;
        end else if (hit && kind == OP_WRITE) begin
            cnt <= (32'(cnt) + 32'd1 < 32'(WRITE_DELAY)) ? cnt + CNT_W'(1) : '0;
        end else begin
            cnt <= '0;
        end
    end

    // Read pipeline: captures the pre-edge storage byte (or zero when the
    // address misses the window) and delays it to match the read latency.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < STAGES; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= hit ? fetch : '0;
            for (int i = 1; i < STAGES; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    // Sticky protocol error when the master asks for read and write at once.
    always_ff @(posedge clock) begin
        if (!reset) begin
            err <= 1'b0;
        end else if (kind == OP_CONFLICT) begin
            err <= 1'b1;
        end
    end

endmodule

// File: rtl/ext_mem_slave.sv
// Off-chip memory slave for the HLS `main` accelerator: fixed-latency
// channels sharing one byte array, plus a preload port and error flags.
module ext_mem_slave
    import ext_mem_pkg::*;
#(
    parameter int CHANNELS    = DEF_CHANNELS,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int SIZE_W      = DEF_SIZE_W,
    parameter int MEMSIZE     = DEF_MEMSIZE,
    parameter int BASE_ADDR   = DEF_BASE_ADDR,
    parameter int READ_DELAY  = DEF_READ_DELAY,
    parameter int WRITE_DELAY = DEF_WRITE_DELAY
)
(
    input  logic                clock,
    input  logic                reset,
    ext_mem_slave_if.slave      bus,
    input  logic                load_en,
    input  logic [ADDR_W-1:0]   load_addr,
    input  logic [DATA_W-1:0]   load_data,
    output logic                error_flag,
    output logic [CHANNELS-1:0] error_chan
);
    localparam int IDX_W = $clog2(MEMSIZE);

    logic [DATA_W-1:0]   mem      [MEMSIZE];
    logic [DATA_W-1:0]   mem_next [MEMSIZE];
    logic [IDX_W-1:0]    ch_off   [CHANNELS];
    logic [DATA_W-1:0]   ch_mask  [CHANNELS];
    logic [CHANNELS-1:0] ch_wr_en;
    logic                load_hit;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        ext_mem_channel #(
            .ADDR_W      (ADDR_W),
            .DATA_W      (DATA_W),
            .SIZE_W      (SIZE_W),
            .MEMSIZE     (MEMSIZE),
            .BASE_ADDR   (BASE_ADDR),
            .READ_DELAY  (READ_DELAY),
            .WRITE_DELAY (WRITE_DELAY)
        ) u_chan (
            .clock    (clock),
            .reset    (reset),
            .oe       (bus.Mout_oe_ram[c]),
            .we       (bus.Mout_we_ram[c]),
            .addr     (bus.Mout_addr_ram[c*ADDR_W +: ADDR_W]),
            .size     (bus.Mout_data_ram_size[c*SIZE_W +: SIZE_W]),
            .fetch    (mem[ch_off[c]]),
            .off      (ch_off[c]),
            .wr_en    (ch_wr_en[c]),
            .wr_mask  (ch_mask[c]),
            .rdata    (bus.M_Rdata_ram[c*DATA_W +: DATA_W]),
            .data_rdy (bus.M_DataRdy[c]),
            .err      (error_chan[c])
        );
    end

    assign load_hit = load_en && in_range(32'(load_addr), 0, MEMSIZE);

    // Next storage image: preload first, then channels in index order, each
    // merging onto the result of the previous writer so later wins per bit.
    always_comb begin
        mem_next = mem;
        if (reset) begin
            if (load_hit) begin
                mem_next[load_addr[IDX_W-1:0]] = load_data;
            end
            for (int c = 0; c < CHANNELS; c++) begin
                if (ch_wr_en[c]) begin
                    mem_next[ch_off[c]] = (bus.Mout_Wdata_ram[c*DATA_W +: DATA_W] & ch_mask[c])
                                        | (mem_next[ch_off[c]] & ~ch_mask[c]);
                end
            end
        end
    end

    // Storage is deliberately not reset so preloaded contents survive.
    always_ff @(posedge clock) begin
        mem <= mem_next;
    end

    // Global sticky error, raised on any channel's oe/we conflict.
    always_ff @(posedge clock) begin
        if (!reset) begin
            error_flag <= 1'b0;
        end else if (|(bus.Mout_oe_ram & bus.Mout_we_ram)) begin
            error_flag <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ext_mem_slave.sv
// Self-checking bench for ext_mem_slave: randomized two-cycle transaction
// slots checked against a byte-array reference, then directed corner cases.
module tb_ext_mem_slave;
    localparam int CHANNELS = 2;
    localparam int ADDR_W   = 7;
    localparam int DATA_W   = 8;
    localparam int SIZE_W   = 4;
    localparam int MEMSIZE  = 32;
    localparam int OP_IDLE  = 0;
    localparam int OP_RD    = 1;
    localparam int OP_WR    = 2;

    logic                clock = 1'b0;
    logic                reset = 1'b0;
    logic                load_en;
    logic [ADDR_W-1:0]   load_addr;
    logic [DATA_W-1:0]   load_data;
    logic                error_flag;
    logic [CHANNELS-1:0] error_chan;

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] mem_model  [MEMSIZE];
    logic [DATA_W-1:0] last_rdata [CHANNELS];

    ext_mem_slave_if #(
        .CHANNELS (CHANNELS),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .SIZE_W   (SIZE_W)
    ) bus ();

    ext_mem_slave #(
        .CHANNELS    (CHANNELS),
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .SIZE_W      (SIZE_W),
        .MEMSIZE     (MEMSIZE),
        .BASE_ADDR   (0),
        .READ_DELAY  (2),
        .WRITE_DELAY (1)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .error_flag (error_flag),
        .error_chan (error_chan)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] maskOf(input int size);
        if (size >= DATA_W) return 8'hFF;
        return 8'((1 << size) - 1);
    endfunction

    task automatic setChan(input int c, input bit oe, input bit we, input int addr,
                           input int wdata, input int size);
        bus.Mout_oe_ram[c] = oe;
        bus.Mout_we_ram[c] = we;
        bus.Mout_addr_ram[c*ADDR_W +: ADDR_W] = ADDR_W'(addr);
        bus.Mout_Wdata_ram[c*DATA_W +: DATA_W] = DATA_W'(wdata);
        bus.Mout_data_ram_size[c*SIZE_W +: SIZE_W] = SIZE_W'(size);
    endtask

    task automatic idleAll();
        for (int c = 0; c < CHANNELS; c++) setChan(c, 1'b0, 1'b0, 0, 0, 0);
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;
    endtask

    task automatic loadByte(input int a, input int d);
        load_en   = 1'b1;
        load_addr = ADDR_W'(a);
        load_data = DATA_W'(d);
        @(posedge clock);
        if (a < MEMSIZE) mem_model[a] = DATA_W'(d);
        #1;
        load_en = 1'b0;
    endtask

    // One slot: cycle 0 presents reads/writes (+ optional load), cycle 1
    // keeps reads held and drops everything else.
    task automatic applyStimulus(input int op0, input int a0, input int d0, input int s0,
                                 input int op1, input int a1, input int d1, input int s1,
                                 input bit ld, input int ld_a, input int ld_d);
        int op [CHANNELS];
        int ad [CHANNELS];
        int wd [CHANNELS];
        int sz [CHANNELS];
        logic [7:0] exp_rd [CHANNELS];
        logic [7:0] m;
        op[0] = op0; ad[0] = a0; wd[0] = d0; sz[0] = s0;
        op[1] = op1; ad[1] = a1; wd[1] = d1; sz[1] = s1;
        for (int c = 0; c < CHANNELS; c++) begin
            setChan(c, op[c] == OP_RD, op[c] == OP_WR, ad[c], wd[c], sz[c]);
            exp_rd[c] = (ad[c] < MEMSIZE) ? mem_model[ad[c]] : 8'h00;
        end
        load_en   = ld;
        load_addr = ADDR_W'(ld_a);
        load_data = DATA_W'(ld_d);
        @(negedge clock);
        for (int c = 0; c < CHANNELS; c++)
            checkOutput($sformatf("rdy%0d_first", c), 32'(bus.M_DataRdy[c]),
                        32'(op[c] == OP_WR && ad[c] < MEMSIZE));
        @(posedge clock);
        if (ld && ld_a < MEMSIZE) mem_model[ld_a] = DATA_W'(ld_d);
        for (int c = 0; c < CHANNELS; c++) begin
            if (op[c] == OP_WR && ad[c] < MEMSIZE) begin
                m = maskOf(sz[c]);
                mem_model[ad[c]] = (DATA_W'(wd[c]) & m) | (mem_model[ad[c]] & ~m);
            end
        end
        #1;
        load_en = 1'b0;
        for (int c = 0; c < CHANNELS; c++)
            if (op[c] != OP_RD) setChan(c, 1'b0, 1'b0, ad[c], 0, 0);
        @(negedge clock);
        for (int c = 0; c < CHANNELS; c++) begin
            if (op[c] == OP_RD) begin
                last_rdata[c] = bus.M_Rdata_ram[c*DATA_W +: DATA_W];
                checkOutput($sformatf("rdy%0d_second", c), 32'(bus.M_DataRdy[c]),
                            32'(ad[c] < MEMSIZE));
                checkOutput($sformatf("rdata%0d_addr%0d", c, ad[c]), 32'(last_rdata[c]),
                            32'(exp_rd[c]));
            end else begin
                checkOutput($sformatf("rdy%0d_second", c), 32'(bus.M_DataRdy[c]), 32'd0);
            end
        end
        @(posedge clock);
        #1;
        idleAll();
    endtask

    initial begin
        idleAll();
        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset_rdy", 32'(bus.M_DataRdy), 32'd0);
        checkOutput("reset_rdata", 32'(bus.M_Rdata_ram), 32'd0);
        checkOutput("reset_err_flag", 32'(error_flag), 32'd0);
        checkOutput("reset_err_chan", 32'(error_chan), 32'd0);
        reset = 1'b1;

        for (int a = 0; a < MEMSIZE; a++) loadByte(a, int'($urandom_range(0, 255)));
        loadByte(35, 8'hEE);

        for (int s = 0; s < 80; s++) begin
            int op0, op1, a0, a1;
            op0 = int'($urandom_range(0, 2));
            op1 = int'($urandom_range(0, 2));
            a0  = ($urandom % 2 == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 39));
            a1  = ($urandom % 2 == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 39));
            applyStimulus(op0, a0, int'($urandom_range(0, 255)), int'($urandom_range(0, 15)),
                          op1, a1, int'($urandom_range(0, 255)), int'($urandom_range(0, 15)),
                          ($urandom % 4) == 0, int'($urandom_range(0, 40)),
                          int'($urandom_range(0, 255)));
        end
        checkOutput("random_no_error", 32'(error_flag), 32'd0);

        // Preloaded byte read back with two-cycle latency.
        loadByte(5, 8'hA5);
        applyStimulus(OP_RD, 5, 0, 0, OP_IDLE, 0, 0, 0, 1'b0, 0, 0);
        checkOutput("d1_preload_read", 32'(last_rdata[0]), 32'h A5);

        // Partial-size write merges with existing contents.
        loadByte(3, 8'h00);
        applyStimulus(OP_IDLE, 0, 0, 0, OP_WR, 3, 8'hFF, 4, 1'b0, 0, 0);
        applyStimulus(OP_IDLE, 0, 0, 0, OP_RD, 3, 0, 0, 1'b0, 0, 0);
        checkOutput("d2_masked_write", 32'(last_rdata[1]), 32'h0F);

        // Same-address writes: channel 1 wins; reads see pre-edge contents.
        applyStimulus(OP_WR, 7, 8'h11, 8, OP_WR, 7, 8'h22, 8, 1'b0, 0, 0);
        applyStimulus(OP_RD, 7, 0, 0, OP_WR, 7, 8'h33, 8, 1'b0, 0, 0);
        checkOutput("d3_collision_winner", 32'(last_rdata[0]), 32'h22);
        applyStimulus(OP_RD, 7, 0, 0, OP_IDLE, 0, 0, 0, 1'b0, 0, 0);
        checkOutput("d3_after_write", 32'(last_rdata[0]), 32'h33);

        // Out-of-range read held for three cycles.
        setChan(0, 1'b1, 1'b0, 40, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checkOutput($sformatf("d4_oob_rdy_%0d", i), 32'(bus.M_DataRdy[0]), 32'd0);
            if (i > 0) checkOutput($sformatf("d4_oob_rdata_%0d", i),
                                   32'(bus.M_Rdata_ram[7:0]), 32'd0);
            @(posedge clock);
            #1;
        end
        idleAll();

        // Conflicting oe+we on channel 1: sticky error, no storage change.
        setChan(1, 1'b1, 1'b1, 5, 8'h5A, 8);
        @(negedge clock);
        checkOutput("d5_err_chan_before", 32'(error_chan), 32'd0);
        checkOutput("d5_err_flag_before", 32'(error_flag), 32'd0);
        @(posedge clock);
        #1;
        idleAll();
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checkOutput($sformatf("d5_err_chan_%0d", i), 32'(error_chan), 32'h2);
            checkOutput($sformatf("d5_err_flag_%0d", i), 32'(error_flag), 32'd1);
            @(posedge clock);
            #1;
        end
        applyStimulus(OP_RD, 5, 0, 0, OP_IDLE, 0, 0, 0, 1'b0, 0, 0);
        checkOutput("d5_storage_kept", 32'(last_rdata[0]), 32'hA5);
        checkOutput("d5_err_still_set", 32'(error_chan), 32'h2);

        // Reset in the middle of a read drops it but keeps storage.
        setChan(0, 1'b1, 1'b0, 5, 0, 0);
        @(negedge clock);
        checkOutput("d6_rdy_first", 32'(bus.M_DataRdy[0]), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        checkOutput("d6_rdy_before_edge", 32'(bus.M_DataRdy[0]), 32'd1);
        @(posedge clock);
        #1;
        checkOutput("d6_rdy_after_reset", 32'(bus.M_DataRdy[0]), 32'd0);
        checkOutput("d6_rdata_cleared", 32'(bus.M_Rdata_ram), 32'd0);
        checkOutput("d6_err_chan_cleared", 32'(error_chan), 32'd0);
        checkOutput("d6_err_flag_cleared", 32'(error_flag), 32'd0);
        idleAll();
        @(posedge clock);
        #1;
        reset = 1'b1;
        applyStimulus(OP_RD, 5, 0, 0, OP_IDLE, 0, 0, 0, 1'b0, 0, 0);
        checkOutput("d6_preload_survives", 32'(last_rdata[0]), 32'hA5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
